// File: rtl/mult_mac_accum.sv
// mult_mac_accum: accumulates up to N_TERMS 16-bit products into one sum per group and hands it out on valid/ready.
// Optional saturation and overflow flag: define MULT_MAC_SAT_EN.
module mult_mac_accum #(
   parameter int N_TERMS = 8,
   parameter int ACC_W   = 19,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_p,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);
   typedef enum logic {ACC, DONE} state_t;
   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_out_cnt;
   logic             w_accept;
   logic             w_close;
   logic [ACC_W-1:0] w_next;

   assign in_ready  = r_state == ACC;
   assign out_valid = r_state == DONE;
   assign out_sum   = r_sum;
   assign out_cnt   = r_out_cnt;
   assign w_accept  = in_valid & in_ready;
   assign w_close   = in_last | (r_cnt == CNT_W'(N_TERMS - 1));

`ifdef MULT_MAC_SAT_EN
   logic [ACC_W:0] w_raw;
   logic           w_carry;
   logic           r_grp_ovf;
   logic           r_ovf;

   assign w_raw   = {1'b0, r_acc} + (ACC_W + 1)'(in_p);
   assign w_carry = w_raw[ACC_W];
   // once clamped at all-ones, any further non-zero term carries again, so the clamp holds for the group
   assign w_next  = w_carry ? '1 : w_raw[ACC_W-1:0];
   assign out_ovf = r_ovf;

   // sticky per-group overflow, published with the sum and cleared for the next group
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grp_ovf <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (w_accept) begin
         if (w_close) begin
            r_ovf     <= r_grp_ovf | w_carry;
            r_grp_ovf <= 1'b0;
         end else begin
            r_grp_ovf <= r_grp_ovf | w_carry;
         end
      end
   end
`else
   assign w_next  = r_acc + ACC_W'(in_p);
   assign out_ovf = 1'b0;
`endif

   // group accumulation and result hand-off; the accumulator restarts at 0 for each group
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ACC;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sum     <= '0;
         r_out_cnt <= '0;
      end else if (r_state == ACC) begin
         if (w_accept) begin
            if (w_close) begin
               r_sum     <= w_next;
               r_out_cnt <= r_cnt + CNT_W'(1);
               r_acc     <= '0;
               r_cnt     <= '0;
               r_state   <= DONE;
            end else begin
               r_acc <= w_next;
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end else if (out_ready) begin
         r_state <= ACC;
      end
   end
endmodule

// File: tb/tb_mult_mac_accum.sv
// tb_mult_mac_accum: directed and random groups checked against an arithmetic model, on a 19-bit and a 16-bit instance.
module tb_mult_mac_accum;
   localparam int N = 8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_p = '0;
   logic        in_ready, out_valid, out_ovf;
   logic [18:0] out_sum;
   logic [3:0]  out_cnt;
   logic        in_ready16, out_valid16, out_ovf16;
   logic [15:0] out_sum16;
   logic [3:0]  out_cnt16;
   int          n_tests = 0;
   int          n_fail = 0;
   int          prods[$];

   always #5 clk = ~clk;

   mult_mac_accum #(.N_TERMS(N), .ACC_W(19), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cnt(out_cnt), .out_ovf(out_ovf));

   mult_mac_accum #(.N_TERMS(N), .ACC_W(16), .CNT_W(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_p(in_p), .in_last(in_last),
      .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16), .out_cnt(out_cnt16), .out_ovf(out_ovf16));

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint exp_sum(input longint total, input int w);
      longint mx = (64'd1 << w) - 1;
`ifdef MULT_MAC_SAT_EN
      return total > mx ? mx : total;
`else
      return total & mx;
`endif
   endfunction

   function automatic longint exp_ovf(input longint total, input int w);
`ifdef MULT_MAC_SAT_EN
      return longint'(total > ((64'd1 << w) - 1));
`else
      return 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_group(input bit use_last, input int gap_lo, input int gap_hi, input int stall);
      longint total = 0;
      int     n = prods.size();
      longint e19, e16;
      for (int i = 0; i < n; i++) begin
         int g = $urandom_range(gap_lo, gap_hi);
         for (int k = 0; k < g; k++) begin
            in_valid = 1'b0;
            tick();
            check("idle_out_valid", out_valid, 0);
         end
         in_valid = 1'b1;
         in_p     = 16'(prods[i]);
         in_last  = use_last && (i == n - 1);
         check("in_ready", in_ready, 1);
         total += prods[i];
         tick();
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      e19 = exp_sum(total, 19);
      e16 = exp_sum(total, 16);
      check("out_valid", out_valid, 1);
      check("out_sum", out_sum, e19);
      check("out_cnt", out_cnt, n);
      check("out_ovf", out_ovf, exp_ovf(total, 19));
      check("out_sum16", out_sum16, e16);
      check("out_ovf16", out_ovf16, exp_ovf(total, 16));
      check("busy_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_p     = 16'($urandom_range(0, 65535));
      in_last  = 1'b1;
      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_sum", out_sum, e19);
         check("stall_cnt", out_cnt, n);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("xfer_out_valid", out_valid, 0);
      check("xfer_in_ready", in_ready, 1);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_cnt", out_cnt, 0);
      check("rst_out_ovf", out_ovf, 0);

      prods = {65025, 65025, 65025, 65025, 65025, 65025, 65025, 65025};
      run_group(1'b0, 0, 0, 0);
      prods = {3, 10, 7};
      run_group(1'b1, 0, 0, 0);
      prods = {1, 1};
      run_group(1'b1, 0, 0, 5);
      prods = {100, 100, 100, 100};
      run_group(1'b1, 2, 2, 1);
      prods = {65025, 1000};
      run_group(1'b1, 0, 0, 0);
      prods = {0};
      run_group(1'b1, 0, 1, 0);

      prods = {500, 500};
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_p     = 16'(prods[i]);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_sum", out_sum, 0);
      check("mid_rst_out_cnt", out_cnt, 0);
      prods = {9};
      run_group(1'b1, 0, 0, 0);

      for (int t = 0; t < 30; t++) begin
         int n = $urandom_range(1, N);
         bit big = $urandom_range(0, 1) == 1;
         prods.delete();
         for (int i = 0; i < n; i++) prods.push_back(big ? $urandom_range(60000, 65535) : $urandom_range(0, 65535));
         run_group(n < N ? 1'b1 : 1'(($urandom_range(0, 1))), 0, 2, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
